// File: rtl/scoreboard_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_register_file_pkg
// Description : Shared types for the scoreboarded register file. The word and
//               address types describe the default 32 x 32-bit configuration.
//               The modules size their own ports from XLEN/NREGS.
// Revision    : 1.0 - initial release
// ============================================================================
package scoreboard_register_file_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_NREGS);

  typedef logic [DEFAULT_XLEN-1:0] word_t;
  typedef logic [DEFAULT_AW-1:0]   reg_address_t;

  // Storage sweep state: clearing after reset, then normal operation.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int pend_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard_register_file_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register outstanding-write counters with saturation and
//               sticky overflow/underflow flags. Register 0 never counts.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               enable            - counters update only while high
//               iss_valid/addr    - issue of an instruction writing addr
//               wb_valid/addr     - write-back to addr
//               busy[NREGS]       - counter nonzero
//               last_pending[NREGS] - counter equals one
//               sb_overflow       - sticky: issue to a saturated counter
//               sb_underflow      - sticky: write-back to a zero counter
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import scoreboard_register_file_pkg::*;
#(
  parameter  int NREGS  = 32,
  parameter  int PEND_W = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREGS-1:0] busy,
  output logic [NREGS-1:0] last_pending,
  output logic             sb_overflow,
  output logic             sb_underflow
);

  localparam logic [PEND_W-1:0] C_PEND_MAX = PEND_W'(pend_max(PEND_W));
  localparam logic [PEND_W-1:0] C_PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] r_pend [NREGS];
  logic              r_overflow;
  logic              r_underflow;

  logic w_inc_req;
  logic w_dec_req;
  logic w_same;
  logic w_inc;
  logic w_dec;
  logic w_ovf;
  logic w_unf;

  assign w_inc_req = enable && iss_valid && (iss_addr != '0);
  assign w_dec_req = enable && wb_valid  && (wb_addr  != '0);
  // An issue and a write-back to the same register cancel out.
  assign w_same    = w_inc_req && w_dec_req && (iss_addr == wb_addr);
  assign w_inc     = w_inc_req && !w_same;
  assign w_dec     = w_dec_req && !w_same;
  assign w_ovf     = w_inc && (r_pend[iss_addr] == C_PEND_MAX);
  assign w_unf     = w_dec && (r_pend[wb_addr]  == '0);

  // w_inc and w_dec address different registers whenever both are set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_pend[i] <= '0;
      end
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_inc && !w_ovf) begin
        r_pend[iss_addr] <= r_pend[iss_addr] + C_PEND_ONE;
      end
      if (w_dec && !w_unf) begin
        r_pend[wb_addr] <= r_pend[wb_addr] - C_PEND_ONE;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_unf) begin
        r_underflow <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_busy
    assign busy[i]         = (r_pend[i] != '0);
    assign last_pending[i] = (r_pend[i] == C_PEND_ONE);
  end

  assign sb_overflow  = r_overflow;
  assign sb_underflow = r_underflow;

endmodule
`default_nettype wire

// File: rtl/scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_register_file
// Description : Register file with NREAD combinational read ports, one
//               write-back port and a per-register outstanding-write
//               scoreboard. Register 0 reads as zero. After reset the storage
//               is cleared one register per cycle; ready stays low until the
//               sweep completes and all reads return zero meanwhile.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               ready                 - sweep finished
//               rd_addr/rd_data/rd_busy - read ports, port p at slice p
//               iss_valid, iss_addr   - issue of a register writer
//               wb_valid, wb_addr, wb_data - write-back port
//               sb_overflow, sb_underflow  - sticky scoreboard errors
// Options     : REGFILE_BYPASS_EN - forward same-cycle write-back data (and
//               the resulting busy state) to matching read ports
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NREAD  = 2,
  parameter  int PEND_W = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  sb_overflow,
  output logic                  sb_underflow
);

  localparam logic [AW-1:0] C_LAST_REG = AW'(NREGS - 1);

  rf_state_t         r_state;
  logic [AW-1:0]     r_sweep;
  logic              r_ready;
  logic [XLEN-1:0]   r_regs [NREGS];

  logic              w_running;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [XLEN-1:0]   w_wdata;
  logic [NREGS-1:0]  w_busy;
  logic [NREGS-1:0]  w_last_pending;

  assign w_running = (r_state == RF_RUN);

  // Sweep FSM: the sweep starts at register 1 because register 0 is never
  // read from storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_sweep <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          if (r_sweep == C_LAST_REG) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
          end else begin
            r_sweep <= r_sweep + AW'(1);
          end
        end
        RF_RUN: begin
        end
      endcase
    end
  end

  // Single storage write port shared by the clear sweep and write-back.
  assign w_we    = !w_running || (wb_valid && (wb_addr != '0));
  assign w_waddr = w_running ? wb_addr : r_sweep;
  assign w_wdata = w_running ? wb_data : '0;

  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .enable       (w_running),
    .iss_valid    (iss_valid),
    .iss_addr     (iss_addr),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .busy         (w_busy),
    .last_pending (w_last_pending),
    .sb_overflow  (sb_overflow),
    .sb_underflow (sb_underflow)
  );

`ifndef REGFILE_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^w_last_pending;
`endif

  for (genvar p = 0; p < NREAD; p++) begin : g_rd_port
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_port_busy;

    assign w_addr = rd_addr[p*AW +: AW];

    always_comb begin
      w_data      = '0;
      w_port_busy = 1'b0;
      if (r_ready) begin
        if (w_addr != '0) begin
          w_data = r_regs[w_addr];
        end
        w_port_busy = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && (wb_addr != '0) && (wb_addr == w_addr)) begin
          w_data = wb_data;
          // This write-back retires the last outstanding write unless a new
          // writer to the same register issues in the same cycle.
          if (w_last_pending[w_addr] && !(iss_valid && (iss_addr == w_addr))) begin
            w_port_busy = 1'b0;
          end
        end
`endif
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_data;
    assign rd_busy[p]              = w_port_busy;
  end

  assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_scoreboard_register_file
// Description : Self-checking bench for scoreboard_register_file. A driver
//               queues expected outputs from a behavioural model; a monitor
//               compares them against the DUT on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_register_file;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int PEND_W = 2;
  localparam int AW     = 5;
  localparam int PMAX   = (1 << PEND_W) - 1;

  localparam int XLEN2  = 64;
  localparam int NREGS2 = 16;
  localparam int NREAD2 = 3;
  localparam int AW2    = 4;

  logic                  clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  ready;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  sb_overflow;
  logic                  sb_underflow;

  logic                    reset2;
  logic                    ready2;
  logic [NREAD2*AW2-1:0]   rd_addr2;
  logic [NREAD2*XLEN2-1:0] rd_data2;
  logic [NREAD2-1:0]       rd_busy2;
  logic                    wb_valid2;
  logic [AW2-1:0]          wb_addr2;
  logic [XLEN2-1:0]        wb_data2;
  logic                    sb_overflow2;
  logic                    sb_underflow2;

  scoreboard_register_file #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
  );

  scoreboard_register_file #(
    .XLEN(XLEN2), .NREGS(NREGS2), .NREAD(NREAD2), .PEND_W(PEND_W)
  ) dut2 (
    .clk(clk), .reset(reset2), .ready(ready2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .iss_valid(1'b0), .iss_addr(4'd0),
    .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .sb_overflow(sb_overflow2), .sb_underflow(sb_underflow2)
  );

  typedef struct packed {
    logic                  rdy;
    logic                  ovf;
    logic                  unf;
    logic [NREAD*XLEN-1:0] data;
    logic [NREAD-1:0]      busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_pend [NREGS];
  bit              m_ready = 1'b0;
  bit              m_ovf   = 1'b0;
  bit              m_unf   = 1'b0;
  int              m_left  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Outstanding-write count register a will hold after the coming edge.
  function automatic int pend_after(input int a);
    int v;
    bit inc;
    bit dec;
    v   = m_pend[a];
    inc = iss_valid && (int'(iss_addr) == a);
    dec = wb_valid  && (int'(wb_addr)  == a);
    if (a == 0) return 0;
    if (inc && !dec && v < PMAX) v++;
    if (dec && !inc && v > 0) v--;
    return v;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   a;
    e.rdy  = m_ready;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.data = '0;
    e.busy = '0;
    if (m_ready) begin
      for (int p = 0; p < NREAD; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        e.data[p*XLEN +: XLEN] = (a == 0) ? '0 : m_regs[a];
        e.busy[p]              = (m_pend[a] != 0);
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && a != 0 && int'(wb_addr) == a) begin
          e.data[p*XLEN +: XLEN] = wb_data;
          e.busy[p]              = (pend_after(a) != 0);
        end
`endif
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    int ia;
    int wa;
    ia = int'(iss_addr);
    wa = int'(wb_addr);
    if (reset) begin
      m_ready = 1'b0;
      m_left  = NREGS - 1;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        m_pend[i] = 0;
        m_regs[i] = '0;
      end
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      if (iss_valid && ia != 0 && !(wb_valid && wa == ia) && m_pend[ia] == PMAX) m_ovf = 1'b1;
      if (wb_valid && wa != 0 && !(iss_valid && ia == wa) && m_pend[wa] == 0) m_unf = 1'b1;
      for (int i = 0; i < NREGS; i++) m_pend[i] = pend_after(i);
      if (wb_valid && wa != 0) m_regs[wa] = wb_data;
    end
  endtask

  // One cycle: queue the expectation for the current inputs, then advance.
  task automatic step();
    exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_addr  = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic rand_inputs();
    iss_valid = ($urandom_range(0, 3) == 0);
    iss_addr  = AW'($urandom);
    wb_valid  = ($urandom_range(0, 1) == 1);
    wb_addr   = AW'($urandom);
    wb_data   = $urandom;
    for (int p = 0; p < NREAD; p++) begin
      rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? wb_addr : AW'($urandom);
    end
  endtask

  task automatic sweep_run(output int edges);
    edges = 0;
    while (!ready && edges < 100) begin
      rand_inputs();
      step();
      edges++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("ready",        64'(ready),        64'(mon_e.rdy));
      chk("rd_data",      64'(rd_data),      64'(mon_e.data));
      chk("rd_busy",      64'(rd_busy),      64'(mon_e.busy));
      chk("sb_overflow",  64'(sb_overflow),  64'(mon_e.ovf));
      chk("sb_underflow", 64'(sb_underflow), 64'(mon_e.unf));
    end
  end

  initial begin : main
    int              edges;
    logic [XLEN2-1:0] dv [3];
    int              a2 [3];

    reset     = 1'b1;
    reset2    = 1'b1;
    rd_addr   = '0;
    rd_addr2  = '0;
    wb_valid2 = 1'b0;
    wb_addr2  = '0;
    wb_data2  = '0;
    idle();

    // Reset, then the initial clear sweep.
    @(posedge clk);
    model_edge();
    #2;
    step();
    reset = 1'b0;
    sweep_run(edges);
    chk("sweep_len", 64'(edges), 64'd31);

    // Scoreboard: two issues, two write-backs, then issue + write-back at count 1.
    idle(); set_rd(7, 7);
    iss_valid = 1'b1; iss_addr = 5'd7;
    step(); step();
    idle(); step();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    step(); step();
    idle(); step();
    iss_valid = 1'b1; iss_addr = 5'd7; step();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h78; step();
    idle(); step();
    chk("x7_busy_after_iss_wb", 64'(rd_busy[0]), 64'd1);

    // Overflow on x3, underflow on x9.
    set_rd(3, 9);
    iss_valid = 1'b1; iss_addr = 5'd3;
    repeat (4) step();
    idle(); step();
    chk("overflow_flag", 64'(sb_overflow), 64'd1);
    chk("x3_busy", 64'(rd_busy[0]), 64'd1);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD;
    step();
    idle(); step();
    chk("underflow_flag", 64'(sb_underflow), 64'd1);
    chk("x9_written", 64'(rd_data[XLEN +: XLEN]), 64'h ABCD);

    // x5 = 123, write to x0 is dropped.
    set_rd(5, 0);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'd123;
`ifdef REGFILE_BYPASS_EN
    #1;
    chk("x5_bypass", 64'(rd_data[0 +: XLEN]), 64'd123);
`endif
    step();
    wb_addr = 5'd0; wb_data = 32'd7;
    step();
    idle(); step();
    chk("x5_read", 64'(rd_data[0 +: XLEN]), 64'd123);
    chk("x0_read", 64'(rd_data[XLEN +: XLEN]), 64'd0);

    // Random traffic fills registers and exercises the scoreboard.
    repeat (400) begin
      rand_inputs();
      step();
    end

    // Reset mid-sweep: the sweep restarts from register 1.
    reset = 1'b1; rand_inputs(); step();
    reset = 1'b0;
    repeat (10) begin
      rand_inputs();
      step();
    end
    reset = 1'b1; rand_inputs(); step();
    reset = 1'b0;
    sweep_run(edges);
    chk("midsweep_len", 64'(edges), 64'd31);
    repeat (150) begin
      rand_inputs();
      step();
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Second configuration: 16 x 64-bit, three read ports.
    @(posedge clk); #2;
    reset2 = 1'b0;
    edges  = 0;
    while (!ready2 && edges < 100) begin
      @(posedge clk); #2;
      edges++;
    end
    chk("sweep_len_16", 64'(edges), 64'd15);
    a2[0] = 1; a2[1] = 2; a2[2] = 15;
    for (int k = 0; k < 3; k++) begin
      dv[k]     = {$urandom, $urandom};
      wb_valid2 = 1'b1;
      wb_addr2  = AW2'(a2[k]);
      wb_data2  = dv[k];
      @(posedge clk); #2;
    end
    wb_valid2 = 1'b0;
    for (int k = 0; k < 3; k++) rd_addr2[k*AW2 +: AW2] = AW2'(a2[k]);
    #1;
    for (int k = 0; k < 3; k++) chk("cfg2_rd_data", rd_data2[k*XLEN2 +: XLEN2], dv[k]);
    chk("cfg2_rd_busy", 64'(rd_busy2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
